// File: rtl/pipe_core.sv
// pipe_core: 4-stage (F/D/E/W) pipelined core with on-chip instruction memory and register file.
// Optional macro PIPE_CORE_FWD_EN enables E/W-to-D operand forwarding.
module pipe_core #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 8,
    parameter int IMEM_AW = 9
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [IMEM_AW-1:0] addr,
    input  logic               wr,
    input  logic [31:0]        wdata,
    input  logic               working,
    input  logic [3:0]         rID,
    output logic [DATA_W-1:0]  rdata,
    output logic [IMEM_AW-1:0] pc,
    output logic               halted,
    output logic               illegal,
    output logic [15:0]        retired
);
    typedef enum logic [2:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_XOR
    } alu_op_t;

    logic [31:0]        r_imem [2**IMEM_AW];
    // Sized for the full 4-bit index; entries at or above NREGS are never written and stay 0.
    logic [DATA_W-1:0]  r_regs [16];

    logic [IMEM_AW-1:0] r_pc;
    logic               r_halted;
    logic               r_illegal;
    logic               r_fetchStop;
    logic [15:0]        r_retired;

    logic               r_fValid;
    logic [31:0]        r_ir;

    logic               r_eWrite;
    logic               r_eHalt;
    logic [3:0]         r_eDst;
    alu_op_t            r_eOp;
    logic [DATA_W-1:0]  r_eOpA;
    logic [DATA_W-1:0]  r_eOpB;

    logic               r_wWrite;
    logic               r_wHalt;
    logic [3:0]         r_wDst;
    logic [DATA_W-1:0]  r_wData;

    logic               w_run;
    logic               w_haltInD;
    logic               w_fetch;
    logic [7:0]         w_opcode;
    logic [3:0]         w_rA;
    logic [3:0]         w_rB;
    logic [DATA_W-1:0]  w_srcA;
    logic [DATA_W-1:0]  w_srcB;
    logic               w_dWrite;
    logic               w_dHalt;
    logic               w_dIllegal;
    logic [3:0]         w_dDst;
    alu_op_t            w_dOp;
    logic [DATA_W-1:0]  w_dOpA;
    logic [DATA_W-1:0]  w_dOpB;
    logic [DATA_W-1:0]  w_eResult;

    assign w_run     = working && !r_halted;
    assign w_opcode  = r_ir[31:24];
    assign w_rA      = r_ir[23:20];
    assign w_rB      = r_ir[19:16];
    assign w_haltInD = r_fValid && (w_opcode == 8'hF0);
    assign w_fetch   = w_run && !w_haltInD && !r_fetchStop;

    assign rdata   = (rID < 4'(NREGS)) ? r_regs[rID] : '0;
    assign pc      = r_pc;
    assign halted  = r_halted;
    assign illegal = r_illegal;
    assign retired = r_retired;

    // Operand fetch: the younger E result wins over the older W write, which wins over the regfile.
    always_comb begin
        w_srcA = (w_rA < 4'(NREGS)) ? r_regs[w_rA] : '0;
        w_srcB = (w_rB < 4'(NREGS)) ? r_regs[w_rB] : '0;
`ifdef PIPE_CORE_FWD_EN
        if (w_rA < 4'(NREGS)) begin
            if (r_eWrite && (r_eDst == w_rA)) begin
                w_srcA = w_eResult;
            end else if (r_wWrite && (r_wDst == w_rA)) begin
                w_srcA = r_wData;
            end
        end
        if (w_rB < 4'(NREGS)) begin
            if (r_eWrite && (r_eDst == w_rB)) begin
                w_srcB = w_eResult;
            end else if (r_wWrite && (r_wDst == w_rB)) begin
                w_srcB = r_wData;
            end
        end
`endif
    end

    always_comb begin
        w_dWrite   = 1'b0;
        w_dHalt    = 1'b0;
        w_dIllegal = 1'b0;
        w_dDst     = w_rA;
        w_dOp      = ALU_PASS;
        w_dOpA     = w_srcA;
        w_dOpB     = w_srcB;
        if (r_fValid) begin
            case (w_opcode)
                8'h00: w_dWrite = 1'b0;
                8'h10: begin
                    w_dWrite = 1'b1;
                    w_dDst   = w_rB;
                    w_dOpA   = DATA_W'(r_ir[15:0]);
                end
                8'h20: begin w_dWrite = 1'b1; w_dOp = ALU_ADD; end
                8'h21: begin w_dWrite = 1'b1; w_dOp = ALU_SUB; end
                8'h22: begin w_dWrite = 1'b1; w_dOp = ALU_AND; end
                8'h23: begin w_dWrite = 1'b1; w_dOp = ALU_XOR; end
                8'hF0: w_dHalt = 1'b1;
                default: w_dIllegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (r_eOp)
            ALU_ADD: w_eResult = r_eOpA + r_eOpB;
            ALU_SUB: w_eResult = r_eOpA - r_eOpB;
            ALU_AND: w_eResult = r_eOpA & r_eOpB;
            ALU_XOR: w_eResult = r_eOpA ^ r_eOpB;
            default: w_eResult = r_eOpA;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr && !working) begin
            r_imem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc        <= '0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
            r_fetchStop <= 1'b0;
            r_retired   <= '0;
            r_fValid    <= 1'b0;
            r_ir        <= '0;
            r_eWrite    <= 1'b0;
            r_eHalt     <= 1'b0;
            r_eDst      <= '0;
            r_eOp       <= ALU_PASS;
            r_eOpA      <= '0;
            r_eOpB      <= '0;
            r_wWrite    <= 1'b0;
            r_wHalt     <= 1'b0;
            r_wDst      <= '0;
            r_wData     <= '0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_run) begin
            if (w_fetch) begin
                r_ir     <= r_imem[r_pc];
                r_fValid <= 1'b1;
                r_pc     <= r_pc + 1'b1;
            end else begin
                r_fValid <= 1'b0;
            end
            if (w_haltInD) begin
                r_fetchStop <= 1'b1;
            end
            if (w_dIllegal) begin
                r_illegal <= 1'b1;
            end

            r_eWrite <= w_dWrite;
            r_eHalt  <= w_dHalt;
            r_eDst   <= w_dDst;
            r_eOp    <= w_dOp;
            r_eOpA   <= w_dOpA;
            r_eOpB   <= w_dOpB;

            r_wWrite <= r_eWrite;
            r_wHalt  <= r_eHalt;
            r_wDst   <= r_eDst;
            r_wData  <= w_eResult;

            if (r_wWrite) begin
                if (r_wDst < 4'(NREGS)) begin
                    r_regs[r_wDst] <= r_wData;
                end
                if (r_retired != 16'hFFFF) begin
                    r_retired <= r_retired + 16'd1;
                end
            end
            if (r_wHalt) begin
                r_halted <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_core.sv
// tb_pipe_core: directed scenario tests for pipe_core, plus a small-imem instance for PC wrap and counter saturation.
module tb_pipe_core;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [8:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        working;
    logic [3:0]  rID;
    logic [31:0] rdata;
    logic [8:0]  pc;
    logic        halted;
    logic        illegal;
    logic [15:0] retired;

    logic [1:0]  w2Addr;
    logic        w2Wr;
    logic [31:0] w2Wdata;
    logic        w2Working;
    logic [3:0]  w2RID;
    logic [31:0] w2Rdata;
    logic [1:0]  w2Pc;
    logic        w2Halted;
    logic        w2Illegal;
    logic [15:0] w2Retired;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rv;

    logic [31:0] progMain [13] = '{
        32'h10000080, 32'h10010081, 32'h10020082, 32'h10030083,
        32'h10040084, 32'h10050085, 32'h10060086, 32'h10070087,
        32'h20010000, 32'h21230000, 32'h22450000, 32'h23670000,
        32'hF0000000
    };
    logic [31:0] expMain [8] = '{
        32'h00000101, 32'h00000081, 32'hFFFFFFFF, 32'h00000083,
        32'h00000084, 32'h00000085, 32'h00000001, 32'h00000087
    };

    pipe_core u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .addr    (addr),
        .wr      (wr),
        .wdata   (wdata),
        .working (working),
        .rID     (rID),
        .rdata   (rdata),
        .pc      (pc),
        .halted  (halted),
        .illegal (illegal),
        .retired (retired)
    );

    pipe_core #(.IMEM_AW(2)) u_wrap (
        .clock   (clock),
        .reset_n (reset_n),
        .addr    (w2Addr),
        .wr      (w2Wr),
        .wdata   (w2Wdata),
        .working (w2Working),
        .rID     (w2RID),
        .rdata   (w2Rdata),
        .pc      (w2Pc),
        .halted  (w2Halted),
        .illegal (w2Illegal),
        .retired (w2Retired)
    );

    always #5 clock = ~clock;

    task automatic doReset();
        working   = 1'b0;
        wr        = 1'b0;
        w2Working = 1'b0;
        w2Wr      = 1'b0;
        reset_n   = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic loadWord(input logic [8:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clock);
        wr = 1'b0;
    endtask

    task automatic loadMain();
        for (int i = 0; i < 13; i++) begin
            loadWord(9'(i), progMain[i]);
        end
    endtask

    task automatic readReg(input logic [3:0] idx, output logic [31:0] d);
        rID = idx;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        doReset();
        vectors++;
        if (pc !== 9'd0) begin miscompares++; $display("[TB] FAIL reset_pc: got %0d expected 0", pc); end
        vectors++;
        if (halted !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
        vectors++;
        if (illegal !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal); end
        vectors++;
        if (retired !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_retired: got %0d expected 0", retired); end
        readReg(4'd3, rv);
        vectors++;
        if (rv !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_r3: got %h expected 0", rv); end
        @(negedge clock);
    endtask

    task automatic test_main_program();
        doReset();
        loadMain();
        working = 1'b1;
        repeat (15) @(negedge clock);
        vectors++;
        if (halted !== 1'b0) begin miscompares++; $display("[TB] FAIL main_halt_early: got %b expected 0", halted); end
        @(negedge clock);
        vectors++;
        if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL main_halted: got %b expected 1", halted); end
        vectors++;
        if (retired !== 16'd12) begin miscompares++; $display("[TB] FAIL main_retired: got %0d expected 12", retired); end
        repeat (5) @(negedge clock);
        vectors++;
        if (pc !== 9'd13) begin miscompares++; $display("[TB] FAIL main_pc_frozen: got %0d expected 13", pc); end
        vectors++;
        if (retired !== 16'd12) begin miscompares++; $display("[TB] FAIL main_retired_hold: got %0d expected 12", retired); end
        for (int i = 0; i < 8; i++) begin
            readReg(4'(i), rv);
            vectors++;
            if (rv !== expMain[i]) begin
                miscompares++;
                $display("[TB] FAIL main_r%0d: got %h expected %h", i, rv, expMain[i]);
            end
        end
        working = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_forwarding();
        logic [31:0] expR1;
`ifdef PIPE_CORE_FWD_EN
        expR1 = 32'h14;
`else
        expR1 = 32'h0;
`endif
        doReset();
        loadWord(9'd0, 32'h10F10005);
        loadWord(9'd1, 32'h20110000);
        loadWord(9'd2, 32'h20110000);
        loadWord(9'd3, 32'hF0000000);
        working = 1'b1;
        repeat (7) @(negedge clock);
        vectors++;
        if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL fwd_halted: got %b expected 1", halted); end
        vectors++;
        if (retired !== 16'd3) begin miscompares++; $display("[TB] FAIL fwd_retired: got %0d expected 3", retired); end
        readReg(4'd1, rv);
        vectors++;
        if (rv !== expR1) begin miscompares++; $display("[TB] FAIL fwd_r1: got %h expected %h", rv, expR1); end
        working = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_illegal();
        doReset();
        loadWord(9'd0, 32'h10010011);
        loadWord(9'd1, 32'h55000000);
        loadWord(9'd2, 32'h10020022);
        loadWord(9'd3, 32'hF0000000);
        working = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if (illegal !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_early: got %b expected 0", illegal); end
        @(negedge clock);
        vectors++;
        if (illegal !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_set: got %b expected 1", illegal); end
        repeat (4) @(negedge clock);
        vectors++;
        if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_halted: got %b expected 1", halted); end
        vectors++;
        if (illegal !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_sticky: got %b expected 1", illegal); end
        vectors++;
        if (retired !== 16'd2) begin miscompares++; $display("[TB] FAIL ill_retired: got %0d expected 2", retired); end
        readReg(4'd0, rv);
        vectors++;
        if (rv !== 32'd0) begin miscompares++; $display("[TB] FAIL ill_r0: got %h expected 0", rv); end
        readReg(4'd1, rv);
        vectors++;
        if (rv !== 32'h11) begin miscompares++; $display("[TB] FAIL ill_r1: got %h expected 11", rv); end
        readReg(4'd2, rv);
        vectors++;
        if (rv !== 32'h22) begin miscompares++; $display("[TB] FAIL ill_r2: got %h expected 22", rv); end
        working = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_out_of_range();
        doReset();
        loadWord(9'd0, 32'h10050001);
        loadWord(9'd1, 32'h10090077);
        loadWord(9'd2, 32'h00000000);
        loadWord(9'd3, 32'h00000000);
        loadWord(9'd4, 32'h20590000);
        loadWord(9'd5, 32'hF0000000);
        working = 1'b1;
        repeat (9) @(negedge clock);
        vectors++;
        if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL oor_halted: got %b expected 1", halted); end
        readReg(4'd5, rv);
        vectors++;
        if (rv !== 32'h1) begin miscompares++; $display("[TB] FAIL oor_r5: got %h expected 1", rv); end
        readReg(4'd9, rv);
        vectors++;
        if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL oor_r9: got %h expected 0", rv); end
        readReg(4'd15, rv);
        vectors++;
        if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL oor_r15: got %h expected 0", rv); end
        working = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_freeze();
        doReset();
        loadMain();
        working = 1'b1;
        repeat (6) @(negedge clock);
        working = 1'b0;
        repeat (5) @(negedge clock);
        vectors++;
        if (pc !== 9'd6) begin miscompares++; $display("[TB] FAIL frz_pc: got %0d expected 6", pc); end
        vectors++;
        if (retired !== 16'd3) begin miscompares++; $display("[TB] FAIL frz_retired: got %0d expected 3", retired); end
        readReg(4'd2, rv);
        vectors++;
        if (rv !== 32'h82) begin miscompares++; $display("[TB] FAIL frz_r2: got %h expected 82", rv); end
        readReg(4'd3, rv);
        vectors++;
        if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL frz_r3: got %h expected 0", rv); end
        @(negedge clock);
        working = 1'b1;
        repeat (10) @(negedge clock);
        vectors++;
        if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL frz_halted: got %b expected 1", halted); end
        vectors++;
        if (pc !== 9'd13) begin miscompares++; $display("[TB] FAIL frz_final_pc: got %0d expected 13", pc); end
        vectors++;
        if (retired !== 16'd12) begin miscompares++; $display("[TB] FAIL frz_final_retired: got %0d expected 12", retired); end
        for (int i = 0; i < 8; i++) begin
            readReg(4'(i), rv);
            vectors++;
            if (rv !== expMain[i]) begin
                miscompares++;
                $display("[TB] FAIL frz_r%0d: got %h expected %h", i, rv, expMain[i]);
            end
        end
        working = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_mid_reset();
        doReset();
        loadMain();
        working = 1'b1;
        repeat (10) @(negedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (pc !== 9'd0) begin miscompares++; $display("[TB] FAIL mrst_pc: got %0d expected 0", pc); end
        vectors++;
        if (retired !== 16'd0) begin miscompares++; $display("[TB] FAIL mrst_retired: got %0d expected 0", retired); end
        vectors++;
        if (halted !== 1'b0) begin miscompares++; $display("[TB] FAIL mrst_halted: got %b expected 0", halted); end
        readReg(4'd0, rv);
        vectors++;
        if (rv !== 32'h0) begin miscompares++; $display("[TB] FAIL mrst_r0: got %h expected 0", rv); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (16) @(negedge clock);
        vectors++;
        if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL mrst_rerun_halted: got %b expected 1", halted); end
        vectors++;
        if (retired !== 16'd12) begin miscompares++; $display("[TB] FAIL mrst_rerun_retired: got %0d expected 12", retired); end
        readReg(4'd0, rv);
        vectors++;
        if (rv !== 32'h101) begin miscompares++; $display("[TB] FAIL mrst_rerun_r0: got %h expected 101", rv); end
        readReg(4'd2, rv);
        vectors++;
        if (rv !== 32'hFFFFFFFF) begin miscompares++; $display("[TB] FAIL mrst_rerun_r2: got %h expected ffffffff", rv); end
        working = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_load_guard();
        doReset();
        working = 1'b1;
        addr    = 9'd8;
        wdata   = 32'h10000000;
        wr      = 1'b1;
        repeat (16) @(negedge clock);
        wr      = 1'b0;
        working = 1'b0;
        vectors++;
        if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL guard_halted: got %b expected 1", halted); end
        readReg(4'd0, rv);
        vectors++;
        if (rv !== 32'h101) begin miscompares++; $display("[TB] FAIL guard_r0: got %h expected 101", rv); end
        @(negedge clock);
    endtask

    task automatic test_wrap_saturate();
        logic [31:0] wrapProg [4];
        wrapProg = '{32'h10010011, 32'h10030033, 32'h10040044, 32'h20210000};
        doReset();
        for (int i = 0; i < 4; i++) begin
            w2Addr  = 2'(i);
            w2Wdata = wrapProg[i];
            w2Wr    = 1'b1;
            @(negedge clock);
            w2Wr = 1'b0;
        end
        w2Working = 1'b1;
        repeat (4) @(negedge clock);
        vectors++;
        if (w2Pc !== 2'd0) begin miscompares++; $display("[TB] FAIL wrap_pc: got %0d expected 0", w2Pc); end
        repeat (7) @(negedge clock);
        vectors++;
        if (w2Pc !== 2'd3) begin miscompares++; $display("[TB] FAIL wrap_pc11: got %0d expected 3", w2Pc); end
        vectors++;
        if (w2Retired !== 16'd8) begin miscompares++; $display("[TB] FAIL wrap_retired: got %0d expected 8", w2Retired); end
        w2RID = 4'd2;
        #1;
        vectors++;
        if (w2Rdata !== 32'h22) begin miscompares++; $display("[TB] FAIL wrap_r2: got %h expected 22", w2Rdata); end
        repeat (65537 - 11) @(negedge clock);
        vectors++;
        if (w2Retired !== 16'hFFFE) begin miscompares++; $display("[TB] FAIL sat_before: got %h expected fffe", w2Retired); end
        @(negedge clock);
        vectors++;
        if (w2Retired !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_reach: got %h expected ffff", w2Retired); end
        repeat (20) @(negedge clock);
        vectors++;
        if (w2Retired !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_hold: got %h expected ffff", w2Retired); end
        vectors++;
        if ((w2Halted !== 1'b0) || (w2Illegal !== 1'b0)) begin
            miscompares++;
            $display("[TB] FAIL wrap_flags: got halted=%b illegal=%b expected 0 0", w2Halted, w2Illegal);
        end
        w2Working = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset_n   = 1'b0;
        addr      = '0;
        wr        = 1'b0;
        wdata     = '0;
        working   = 1'b0;
        rID       = '0;
        w2Addr    = '0;
        w2Wr      = 1'b0;
        w2Wdata   = '0;
        w2Working = 1'b0;
        w2RID     = '0;
        test_reset();
        test_main_program();
        test_forwarding();
        test_illegal();
        test_out_of_range();
        test_freeze();
        test_mid_reset();
        test_load_guard();
        test_wrap_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
